// File: rtl/ram_burst_ctrl.sv
// Host-to-async-SRAM burst engine; define RAM_BURST_CTRL_BURST_EN to honour len (1..4 beats), else 1 beat.
// Latency: write strobe closes 2 cycles after the wdata handshake; rdata_valid 2 cycles after RD_ADDR entry.
// Backpressure: stalls in WAIT_WD until wdata_valid; start is ignored unless idle.
module ram_burst_ctrl #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              we,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [1:0]        len,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rw,
  inout  wire  [DATA_W-1:0] ram_data
);

  typedef enum logic [2:0] {
    IDLE, WAIT_WD, WR_SETUP, WR_STROBE, RD_ADDR, RD_CAPT, DONE
  } state_t;

  state_t            state;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic              drive_q;
  logic              last_beat;

`ifdef RAM_BURST_CTRL_BURST_EN
  logic [1:0] len_q;
  logic [1:0] beat_q;

  assign last_beat = (beat_q == len_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q  <= 2'd0;
      beat_q <= 2'd0;
    end else if (state == IDLE && start) begin
      len_q  <= len;
      beat_q <= 2'd0;
    end else if (state == WR_STROBE || state == RD_CAPT) begin
      beat_q <= beat_q + 2'd1;
    end
  end
`else
  logic unused_len;
  assign unused_len = ^len;
  assign last_beat  = 1'b1;
`endif

  // The bus is only ours for the setup/strobe pair; the RAM owns it otherwise.
  assign ram_data = drive_q ? wdata_q : {DATA_W{1'bz}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      rdata_valid <= 1'b0;
      wdata_ready <= 1'b0;
      rdata       <= '0;
      ram_addr    <= '0;
      ram_rw      <= 1'b1;
      drive_q     <= 1'b0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
    end else begin
      done        <= 1'b0;
      rdata_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            we_q     <= we;
            ram_addr <= base_addr;
            busy     <= 1'b1;
            if (we) begin
              state       <= WAIT_WD;
              wdata_ready <= 1'b1;
            end else begin
              state <= RD_ADDR;
            end
          end
        end
        WAIT_WD: begin
          if (wdata_valid) begin
            wdata_q     <= wdata;
            wdata_ready <= 1'b0;
            drive_q     <= 1'b1;
            state       <= WR_SETUP;
          end
        end
        WR_SETUP: begin
          ram_rw <= 1'b0;
          state  <= WR_STROBE;
        end
        RD_ADDR: state <= RD_CAPT;
        // Both beat types finish here: advance the address and pick the next beat or DONE.
        WR_STROBE, RD_CAPT: begin
          if (state == RD_CAPT) begin
            rdata       <= ram_data;
            rdata_valid <= 1'b1;
          end else begin
            ram_rw  <= 1'b1;
            drive_q <= 1'b0;
          end
          ram_addr <= ram_addr + ADDR_W'(1);
          if (last_beat) begin
            state <= DONE;
            done  <= 1'b1;
          end else if (we_q) begin
            state       <= WAIT_WD;
            wdata_ready <= 1'b1;
          end else begin
            state <= RD_ADDR;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ram_burst_ctrl.md
RAM_BURST_CTRL -- requirements
Module: ram_burst_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, RAM word-address width.
REQ-002 SHALL have parameter DATA_W, default 16, RAM data width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  host request pulse; accepted only in IDLE.
REQ-006 SHALL have port we  input  1  request type (1 write, 0 read); sampled with start.
REQ-007 SHALL have port base_addr  input  ADDR_W  first word address; sampled with start.
REQ-008 SHALL have port len  input  2  beats minus one (0..3 gives 1..4 beats); sampled with start.
REQ-009 SHALL have port wdata  input  DATA_W  write beat data.
REQ-010 SHALL have port wdata_valid  input  1  wdata valid.
REQ-011 SHALL have port wdata_ready  output  1  high in WAIT_WD; a beat transfers when wdata_valid and wdata_ready are both high.
REQ-012 SHALL have port rdata  output  DATA_W  captured read word.
REQ-013 SHALL have port rdata_valid  output  1  one-cycle pulse per read beat.
REQ-014 SHALL have port busy  output  1  high in every state except IDLE.
REQ-015 SHALL have port done  output  1  one-cycle pulse after the final beat.
REQ-016 SHALL have port ram_addr  output  ADDR_W  RAM word address.
REQ-017 SHALL have port ram_rw  output  1  RAM direction (1 read, 0 write).
REQ-018 SHALL have port ram_data  inout  DATA_W  shared RAM data bus.

Function
REQ-019 SHALL implement the FSM IDLE, WAIT_WD, WR_SETUP, WR_STROBE, RD_ADDR, RD_CAPT, DONE.
REQ-020 SHALL, on start in IDLE, latch we, base_addr and len into internal registers, clear the beat counter, and enter WAIT_WD if we=1, else RD_ADDR.
REQ-021 SHALL ignore start in every state other than IDLE.
REQ-022 SHALL, in WAIT_WD, hold until wdata_valid, then register wdata and enter WR_SETUP.
REQ-023 SHALL, in WR_SETUP, drive ram_addr, hold ram_rw=1, and drive ram_data from the wdata register.
REQ-024 SHALL, in WR_STROBE, drive ram_rw=0 with ram_addr and ram_data unchanged, so the RAM latches the word on the closing edge of WR_STROBE.
REQ-025 SHALL release ram_data to high-Z in every state except WR_SETUP and WR_STROBE.
REQ-026 SHALL, in RD_ADDR, drive ram_addr with ram_rw=1, then enter RD_CAPT.
REQ-027 SHALL, in RD_CAPT, sample ram_data into rdata at the closing edge and pulse rdata_valid for the following cycle.
REQ-028 SHALL, after each beat, increment the address modulo 2^ADDR_W (4095 wraps to 0) and the beat counter.
REQ-029 SHALL, after the last beat, enter DONE, which pulses done for one cycle and then returns to IDLE.
REQ-030 SHALL return to WAIT_WD (write) or RD_ADDR (read) when beats remain.
REQ-031 SHALL set the per-beat latency to: write 2 cycles after the wdata handshake; read rdata_valid 2 cycles after entering RD_ADDR.
REQ-032 SHALL hold ram_rw=1 in IDLE, DONE and all read states; there SHALL be no write strobe outside WR_STROBE.

Reset
REQ-033 SHALL, when rst_n is low (asynchronously), force state=IDLE, busy=0, done=0, rdata_valid=0, wdata_ready=0, rdata=0, ram_addr=0, ram_rw=1 and ram_data=Z.
REQ-034 SHALL abort any in-flight burst on reset with no further RAM write, and SHALL not resume it after reset is released.

Configuration
REQ-035 SHALL, when macro RAM_BURST_CTRL_BURST_EN is defined, honor len (1..4 beats).
REQ-036 SHALL, when RAM_BURST_CTRL_BURST_EN is undefined, ignore len, treat every request as 1 beat, and omit the beat counter logic.

Verification
REQ-037 SHALL cover single write: start, we=1, base_addr=0x005, wdata=0xBEEF, then a single read of 0x005 -> ram_rw low for exactly 1 cycle; rdata=0xBEEF with one rdata_valid pulse; one done pulse each.
REQ-038 SHALL cover write burst with wrap: base_addr=0xFFE, len=3, data 0x1111..0x4444 -> addresses 0xFFE, 0xFFF, 0x000, 0x001 written; read-back matches in order.
REQ-039 SHALL cover write stall: wdata_valid held low for 5 cycles in WAIT_WD -> no ram_rw=0 pulse, busy stays 1, and ram_data stays Z until the handshake.
REQ-040 SHALL cover start while busy: second start pulse mid-burst -> ignored; only one done pulse and the original beat count.
REQ-041 SHALL cover reset mid-burst: rst_n low during WR_SETUP of beat 2 -> immediate IDLE state with outputs at reset values; beat 2 address left unwritten.
REQ-042 SHALL cover the macro-off build: len=3 request -> exactly 1 beat, then done.
